// File: rtl/led_row_scan_ctrl_pkg.sv
// led_row_scan_ctrl_pkg: shared state encoding and sizing helper for the row-scan sequencer
package led_row_scan_ctrl_pkg;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_SHIFT = 3'd1,
        S_BLANK = 3'd2,
        S_LATCH = 3'd3,
        S_DISP  = 3'd4
    } state_t;

    function automatic int max3(input int a, input int b, input int c);
        int m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

endpackage

// File: rtl/led_phase_cnt.sv
// led_phase_cnt: loadable down-counter with zero flag that times the BLANK/LATCH/DISP phases
module led_phase_cnt #(
    parameter int W = 10
) (
    input  logic         i_clk,
    input  logic         i_RESET_n,
    input  logic         i_load,
    input  logic [W-1:0] i_val,
    output logic         o_zero
);

    logic [W-1:0] cnt_q, cnt_d;

    // load takes priority; otherwise count down and park at zero
    always_comb begin
        cnt_d = i_load ? i_val : ((cnt_q != '0) ? cnt_q - 1'b1 : cnt_q);
    end

    // counter register
    always_ff @(posedge i_clk) begin
        if (!i_RESET_n) cnt_q <= '0;
        else            cnt_q <= cnt_d;
    end

    assign o_zero = (cnt_q == '0);

endmodule

// File: rtl/led_row_scan_ctrl.sv
// led_row_scan_ctrl: row-scan sequencer driving shift, blank, latch and lit phases per LED row
module led_row_scan_ctrl
    import led_row_scan_ctrl_pkg::*;
#(
    parameter int ROWS      = 8,
    parameter int ROW_W     = 3,
    parameter int ON_W      = 10,
    parameter int BLANK_CYC = 4,
    parameter int LATCH_CYC = 1
) (
    input  logic             i_clk,
    input  logic             i_RESET_n,
    input  logic             i_ena,
    input  logic [ON_W-1:0]  i_bright,
    output logic             o_shift_start,
    output logic [ROW_W-1:0] o_shift_row,
    input  logic             i_shift_done,
    output logic             o_latch,
    output logic             o_oe_n,
    output logic [ROW_W-1:0] o_row_addr,
    output logic             o_frame_start,
    output logic             o_busy
);

    localparam int CNT_W = max3(ON_W, $clog2(BLANK_CYC + 1), $clog2(LATCH_CYC + 1));

    state_t           state_q, state_d;
    logic             shift_start_q, shift_start_d;
    logic             frame_start_q, frame_start_d;
    logic [ROW_W-1:0] shift_row_q, shift_row_d;
    logic             latch_q, latch_d;
    logic             oe_n_q, oe_n_d;
    logic [ROW_W-1:0] row_addr_q, row_addr_d;
    logic             busy_q, busy_d;
    logic [ON_W-1:0]  bright_q, bright_d;
    logic             cnt_load;
    logic [CNT_W-1:0] cnt_val;
    logic             cnt_zero;
    logic             row_done;
    logic             wrap;
    logic [ROW_W-1:0] next_row;

    led_phase_cnt #(.W(CNT_W)) u_cnt (
        .i_clk     (i_clk),
        .i_RESET_n (i_RESET_n),
        .i_load    (cnt_load),
        .i_val     (cnt_val),
        .o_zero    (cnt_zero)
    );

    assign wrap     = (shift_row_q == ROW_W'(ROWS - 1));
    assign next_row = wrap ? '0 : shift_row_q + 1'b1;

    // next-state and registered-output logic; phase counter loaded on each timed-state entry
    always_comb begin
        state_d       = state_q;
        shift_start_d = 1'b0;
        frame_start_d = 1'b0;
        shift_row_d   = shift_row_q;
        latch_d       = 1'b0;
        oe_n_d        = oe_n_q;
        row_addr_d    = row_addr_q;
        bright_d      = bright_q;
        cnt_load      = 1'b0;
        cnt_val       = '0;
        row_done      = 1'b0;
        case (state_q)
            S_IDLE: begin
                oe_n_d = 1'b1;
                if (i_ena) begin
                    state_d       = S_SHIFT;
                    shift_start_d = 1'b1;
                    frame_start_d = 1'b1;
                    shift_row_d   = '0;
                    bright_d      = i_bright;
                end
            end
            S_SHIFT: begin
                // a done pulse coinciding with the start pulse belongs to no shift of ours
                if (i_shift_done && !shift_start_q) begin
                    state_d  = S_BLANK;
                    oe_n_d   = 1'b1;
                    cnt_load = 1'b1;
                    cnt_val  = CNT_W'(BLANK_CYC - 1);
                end
            end
            S_BLANK: begin
                oe_n_d = 1'b1;
                if (cnt_zero) begin
                    state_d    = S_LATCH;
                    latch_d    = 1'b1;
                    row_addr_d = shift_row_q;
                    cnt_load   = 1'b1;
                    cnt_val    = CNT_W'(LATCH_CYC - 1);
                end
            end
            S_LATCH: begin
                oe_n_d  = 1'b1;
                latch_d = !cnt_zero;
                if (cnt_zero) begin
                    if (bright_q != '0) begin
                        state_d  = S_DISP;
                        oe_n_d   = 1'b0;
                        cnt_load = 1'b1;
                        cnt_val  = CNT_W'(bright_q - 1'b1);
                    end else begin
                        row_done = 1'b1;
                    end
                end
            end
            S_DISP: begin
                row_done = cnt_zero;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
        // end of a row: enable is only consulted here once a row has started
        if (row_done) begin
            oe_n_d = 1'b1;
            if (i_ena) begin
                state_d       = S_SHIFT;
                shift_start_d = 1'b1;
                shift_row_d   = next_row;
                frame_start_d = wrap;
                bright_d      = wrap ? i_bright : bright_q;
            end else begin
                state_d     = S_IDLE;
                shift_row_d = '0;
            end
        end
        busy_d = (state_d != S_IDLE);
    end

    // state and output registers
    always_ff @(posedge i_clk) begin
        if (!i_RESET_n) begin
            state_q       <= S_IDLE;
            shift_start_q <= 1'b0;
            frame_start_q <= 1'b0;
            shift_row_q   <= '0;
            latch_q       <= 1'b0;
            oe_n_q        <= 1'b1;
            row_addr_q    <= '0;
            busy_q        <= 1'b0;
            bright_q      <= '0;
        end else begin
            state_q       <= state_d;
            shift_start_q <= shift_start_d;
            frame_start_q <= frame_start_d;
            shift_row_q   <= shift_row_d;
            latch_q       <= latch_d;
            oe_n_q        <= oe_n_d;
            row_addr_q    <= row_addr_d;
            busy_q        <= busy_d;
            bright_q      <= bright_d;
        end
    end

    assign o_shift_start = shift_start_q;
    assign o_frame_start = frame_start_q;
    assign o_shift_row   = shift_row_q;
    assign o_latch       = latch_q;
    assign o_oe_n        = oe_n_q;
    assign o_row_addr    = row_addr_q;
    assign o_busy        = busy_q;

endmodule

// File: tb/tb_led_row_scan_ctrl.sv
// tb_led_row_scan_ctrl: directed self-checking bench for the LED row-scan sequencer
module tb_led_row_scan_ctrl;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       ena;
    logic [9:0] bright;
    logic       shift_start;
    logic [2:0] shift_row;
    logic       shift_done;
    logic       latch;
    logic       oe_n;
    logic [2:0] row_addr;
    logic       frame_start;
    logic       busy;

    int sdly  = 16;
    bit early = 1'b0;
    int total = 0;
    int bad   = 0;

    int cyc     = 0;
    int run     = 0;
    int run_adr = 0;
    int latches = 0;
    int st_row[$];
    int st_fs[$];
    int st_cyc[$];
    int runs[$];
    int run_addr[$];

    led_row_scan_ctrl dut (
        .i_clk         (clk),
        .i_RESET_n     (rst_n),
        .i_ena         (ena),
        .i_bright      (bright),
        .o_shift_start (shift_start),
        .o_shift_row   (shift_row),
        .i_shift_done  (shift_done),
        .o_latch       (latch),
        .o_oe_n        (oe_n),
        .o_row_addr    (row_addr),
        .o_frame_start (frame_start),
        .o_busy        (busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    // column shifter model: done pulse sdly cycles after the start pulse, optional stray pulse on the start cycle
    initial begin
        shift_done = 1'b0;
        forever begin
            @(negedge clk);
            if (shift_start && rst_n) begin
                if (early) shift_done = 1'b1;
                @(negedge clk);
                shift_done = 1'b0;
                repeat (sdly - 1) @(negedge clk);
                shift_done = 1'b1;
                @(negedge clk);
                shift_done = 1'b0;
            end
        end
    end

    // recorder sampled just after each active edge
    always @(posedge clk) begin
        #1;
        cyc++;
        if (shift_start) begin
            st_row.push_back(int'(shift_row));
            st_fs.push_back(int'(frame_start));
            st_cyc.push_back(cyc);
        end
        if (!oe_n) begin
            run++;
            run_adr = int'(row_addr);
        end else if (run != 0) begin
            runs.push_back(run);
            run_addr.push_back(run_adr);
            run = 0;
        end
        if (latch) latches++;
    end

    task automatic wait_starts(input int n, input int budget);
        int k = 0;
        while (st_row.size() < n && k < budget) begin
            @(negedge clk);
            k++;
        end
        if (st_row.size() < n) chk("start_timeout", st_row.size(), n);
    endtask

    task automatic do_reset(input int n);
        ena   = 1'b0;
        rst_n = 1'b0;
        repeat (n) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    initial begin
        int b0, r0, l0, k, fs;
        rst_n  = 1'b0;
        ena    = 1'b0;
        bright = 10'd10;
        repeat (3) @(negedge clk);
        chk("rst_oe_n", oe_n, 1);
        chk("rst_busy", busy, 0);
        chk("rst_row_addr", row_addr, 0);
        chk("rst_shift_row", shift_row, 0);
        chk("rst_pulses", {shift_start, frame_start, latch}, 0);
        rst_n = 1'b1;
        @(negedge clk);
        chk("idle_busy", busy, 0);

        // full frame at bright 10, shift takes 16 cycles; bright drops to 3 mid-frame
        b0 = st_row.size();
        r0 = runs.size();
        l0 = latches;
        ena = 1'b1;
        wait_starts(b0 + 4, 200);
        bright = 10'd3;
        wait_starts(b0 + 10, 700);
        for (int i = 0; i < 9; i++) chk($sformatf("row_seq%0d", i), st_row[b0 + i], i % 8);
        fs = 0;
        for (int i = 0; i < 9; i++) fs += st_fs[b0 + i];
        chk("frame_starts", fs, 2);
        chk("fs_row0", st_fs[b0], 1);
        chk("fs_wrap", st_fs[b0 + 8], 1);
        chk("period_b10", st_cyc[b0 + 1] - st_cyc[b0], 32);
        chk("frame_len", st_cyc[b0 + 8] - st_cyc[b0], 256);
        chk("period_b3", st_cyc[b0 + 9] - st_cyc[b0 + 8], 25);
        chk("run_count", runs.size() - r0, 9);
        for (int i = 0; i < 8; i++) chk($sformatf("on_len%0d", i), runs[r0 + i], 10);
        chk("on_len_next_frame", runs[r0 + 8], 3);
        chk("run_addr5", run_addr[r0 + 5], 5);
        chk("latch_count", latches - l0, 9);

        // reset during DISP of row 5
        k = 0;
        while (!(oe_n == 1'b0 && row_addr == 3'd5) && k < 400) begin
            @(negedge clk);
            k++;
        end
        chk("reach_row5_disp", {oe_n, row_addr}, {1'b0, 3'd5});
        rst_n = 1'b0;
        ena   = 1'b0;
        @(negedge clk);
        chk("midrst_oe_n", oe_n, 1);
        chk("midrst_row_addr", row_addr, 0);
        chk("midrst_busy", busy, 0);
        chk("midrst_latch", latch, 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (20) @(negedge clk);
        chk("post_rst_idle", {busy, oe_n, shift_start}, 3'b010);

        // zero brightness: dark, but latch and rows keep going
        bright = 10'd0;
        b0 = st_row.size();
        r0 = runs.size();
        l0 = latches;
        ena = 1'b1;
        wait_starts(b0 + 4, 200);
        chk("b0_no_light", runs.size() - r0 + run, 0);
        chk("b0_latches", latches - l0, 3);
        for (int i = 0; i < 4; i++) chk($sformatf("b0_row%0d", i), st_row[b0 + i], i);
        chk("b0_period", st_cyc[b0 + 1] - st_cyc[b0], 22);
        do_reset(20);

        // enable dropped during SHIFT of row 3
        bright = 10'd5;
        b0 = st_row.size();
        ena = 1'b1;
        k = 0;
        while (!(shift_start && shift_row == 3'd3) && k < 300) begin
            @(negedge clk);
            k++;
        end
        chk("reach_row3_shift", {shift_start, shift_row}, {1'b1, 3'd3});
        ena = 1'b0;
        k = 0;
        while (busy && k < 100) begin
            @(negedge clk);
            k++;
        end
        chk("drop_idle", busy, 0);
        chk("drop_no_row4", st_row.size() - b0, 4);
        chk("drop_last_on", runs[runs.size() - 1], 5);
        chk("drop_last_addr", run_addr[run_addr.size() - 1], 3);
        chk("drop_row_addr_hold", row_addr, 3);
        chk("drop_shift_row", shift_row, 0);
        chk("drop_oe_n", oe_n, 1);
        repeat (5) @(negedge clk);
        ena = 1'b1;
        wait_starts(b0 + 5, 50);
        chk("reen_row", st_row[b0 + 4], 0);
        chk("reen_fs", st_fs[b0 + 4], 1);
        do_reset(20);

        // stray done on the start cycle must be ignored
        early  = 1'b1;
        bright = 10'd10;
        b0 = st_row.size();
        ena = 1'b1;
        wait_starts(b0 + 2, 200);
        chk("early_period", st_cyc[b0 + 1] - st_cyc[b0], 32);
        do_reset(20);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
